// File: rtl/booth_pp_gen32_pkg.sv
// Shared constants, Booth digit encoding and buffer state encoding for the
// radix-4 Booth partial-product generator.
package mult_pkg;

    localparam int OP_W   = 32;
    localparam int PP_W   = 64;
    localparam int NUM_PP = 17;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } buf_state_t;

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] grp);
        booth_digit_t d;
        case (grp)
            3'b000:  d = ZERO;
            3'b001:  d = POS1;
            3'b010:  d = POS1;
            3'b011:  d = POS2;
            3'b100:  d = NEG2;
            3'b101:  d = NEG1;
            3'b110:  d = NEG1;
            default: d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen32_if.sv
// Operand/partial-product bus of booth_pp_gen32. The slave modport is the
// generator's view; the master modport is the producer/consumer view.
interface booth_pp_gen32_if
    import mult_pkg::*;
#(
    parameter int TAG_W = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_tc;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [PP_W-1:0]   P0,  P1,  P2,  P3,  P4,  P5,  P6,  P7,  P8;
    logic [PP_W-1:0]   P9,  P10, P11, P12, P13, P14, P15, P16;

    modport master (
        output in_valid, in_a, in_b, in_tc, in_tag, out_ready,
        input  in_ready, out_valid, out_tag,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8,
        input  P9, P10, P11, P12, P13, P14, P15, P16
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tc, in_tag, out_ready,
        output in_ready, out_valid, out_tag,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8,
        output P9, P10, P11, P12, P13, P14, P15, P16
    );

endinterface

// File: rtl/booth_pp_gen32_row.sv
// One Booth partial-product row: d * A_ext shifted left by SHIFT, kept as a
// full 64-bit two's-complement value (no sign-encoding shortcuts).
module booth_pp_row
    import mult_pkg::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  booth_digit_t      digit,
    input  logic [PP_W-1:0]   a_ext,
    output logic [PP_W-1:0]   pp
);

    logic [PP_W-1:0] mag;
    logic [PP_W-1:0] val;

    // Select |d|*A, apply the sign, then weight by 4^i.
    always_comb begin
        mag = a_ext;
        val = '0;
        case (digit)
            POS2, NEG2: mag = a_ext << 1;
            default:    mag = a_ext;
        endcase
        case (digit)
            POS1, POS2: val = mag;
            NEG1, NEG2: val = ~mag + {{(PP_W-1){1'b0}}, 1'b1};
            default:    val = '0;
        endcase
        pp = val << SHIFT;
    end

endmodule

// File: rtl/booth_pp_gen32.sv
// Radix-4 Booth partial-product generator: 32x32 signed/unsigned operands in,
// 17 registered 64-bit partial products out through a 2-entry skid buffer.
module booth_pp_gen32
    import mult_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    booth_pp_gen32_if.slave  bus
);

    logic [PP_W-1:0] a_ext;
    logic [OP_W+2:0] b_ext;
    logic [PP_W-1:0] pp_new [NUM_PP];

    buf_state_t       state_q,   state_d;
    logic             in_ready_q, in_ready_d;
    logic [PP_W-1:0]  main_pp_q [NUM_PP];
    logic [PP_W-1:0]  main_pp_d [NUM_PP];
    logic [PP_W-1:0]  skid_pp_q [NUM_PP];
    logic [PP_W-1:0]  skid_pp_d [NUM_PP];
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic accept;

    // Operand extension; b_ext[j] holds b[j-1] so b[-1] sits at index 0.
    always_comb begin
        a_ext = bus.in_tc ? {{(PP_W-OP_W){bus.in_a[OP_W-1]}}, bus.in_a}
                          : {{(PP_W-OP_W){1'b0}}, bus.in_a};
        b_ext = {{2{bus.in_tc & bus.in_b[OP_W-1]}}, bus.in_b, 1'b0};
    end

    for (genvar i = 0; i < NUM_PP; i++) begin : g_row
        booth_digit_t digit;
        assign digit = booth_decode(b_ext[2*i+2 -: 3]);

        booth_pp_row #(
            .SHIFT(2 * i)
        ) u_row (
            .digit (digit),
            .a_ext (a_ext),
            .pp    (pp_new[i])
        );
    end

    assign accept = bus.in_valid & in_ready_q;

    // Buffer next state and register loads; in_ready is precomputed from
    // the next state so it leaves a flop with no path from out_ready.
    always_comb begin
        state_d    = state_q;
        main_pp_d  = main_pp_q;
        skid_pp_d  = skid_pp_q;
        main_tag_d = main_tag_q;
        skid_tag_d = skid_tag_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_pp_d  = pp_new;
                    main_tag_d = bus.in_tag;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && bus.out_ready) begin
                    main_pp_d  = pp_new;
                    main_tag_d = bus.in_tag;
                end else if (accept) begin
                    skid_pp_d  = pp_new;
                    skid_tag_d = bus.in_tag;
                    state_d    = FULL;
                end else if (bus.out_ready) begin
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    main_pp_d  = skid_pp_q;
                    main_tag_d = skid_tag_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != FULL);
    end

    // State, ready and data registers; reset discards every in-flight bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_tag_q <= '0;
            skid_tag_q <= '0;
            for (int unsigned i = 0; i < NUM_PP; i++) begin
                main_pp_q[i] <= '0;
                skid_pp_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_tag_q <= main_tag_d;
            skid_tag_q <= skid_tag_d;
            main_pp_q  <= main_pp_d;
            skid_pp_q  <= skid_pp_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_tag   = main_tag_q;
    assign bus.P0  = main_pp_q[0];
    assign bus.P1  = main_pp_q[1];
    assign bus.P2  = main_pp_q[2];
    assign bus.P3  = main_pp_q[3];
    assign bus.P4  = main_pp_q[4];
    assign bus.P5  = main_pp_q[5];
    assign bus.P6  = main_pp_q[6];
    assign bus.P7  = main_pp_q[7];
    assign bus.P8  = main_pp_q[8];
    assign bus.P9  = main_pp_q[9];
    assign bus.P10 = main_pp_q[10];
    assign bus.P11 = main_pp_q[11];
    assign bus.P12 = main_pp_q[12];
    assign bus.P13 = main_pp_q[13];
    assign bus.P14 = main_pp_q[14];
    assign bus.P15 = main_pp_q[15];
    assign bus.P16 = main_pp_q[16];

endmodule

// File: tb/tb_booth_pp_gen32.sv
// Self-checking bench for booth_pp_gen32: directed vectors, backpressure,
// mid-stream reset and a random stream checked against a scoreboard.
module tb_booth_pp_gen32;

    logic clk;
    logic rst;

    booth_pp_gen32_if #(.TAG_W(4)) bus ();

    booth_pp_gen32 #(
        .TAG_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb_q [$];
    int          tests = 0;
    int          fails = 0;
    bit          stall_prev = 0;
    logic [63:0] snap_p0, snap_p16, snap_sum;
    logic [3:0]  snap_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic tc);
        logic [63:0] ea, eb;
        ea = tc ? {{32{a[31]}}, a} : {32'h0, a};
        eb = tc ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] pp_sum();
        return bus.P0 + bus.P1 + bus.P2 + bus.P3 + bus.P4 + bus.P5 + bus.P6 + bus.P7
             + bus.P8 + bus.P9 + bus.P10 + bus.P11 + bus.P12 + bus.P13 + bus.P14
             + bus.P15 + bus.P16;
    endfunction

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Account for the handshakes of the coming edge, then advance one cycle.
    task automatic tick(output bit acc);
        bit   deq;
        exp_t e;
        acc = bus.in_valid && bus.in_ready;
        deq = bus.out_valid && bus.out_ready;
        if (stall_prev) begin
            check64("stable_p0", bus.P0, snap_p0);
            check64("stable_p16", bus.P16, snap_p16);
            check64("stable_sum", pp_sum(), snap_sum);
            check64("stable_tag", {60'h0, bus.out_tag}, {60'h0, snap_tag});
        end
        if (deq) begin
            check64("sb_nonempty", {63'h0, sb_q.size() != 0}, 64'h1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check64("sum", pp_sum(), e.prod);
                check64("tag", {60'h0, bus.out_tag}, {60'h0, e.tag});
            end
        end
        if (acc) begin
            e.prod = ref_prod(bus.in_a, bus.in_b, bus.in_tc);
            e.tag  = bus.in_tag;
            sb_q.push_back(e);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        snap_p0    = bus.P0;
        snap_p16   = bus.P16;
        snap_sum   = pp_sum();
        snap_tag   = bus.out_tag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic tc,
                         input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tc    = tc;
        bus.in_tag   = tag;
    endtask

    // Issue one op with out_ready high; leaves the result presented.
    task automatic direct(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic tc, input logic [3:0] tag);
        bit acc;
        bus.out_ready = 1'b1;
        drive(a, b, tc, tag);
        tick(acc);
        bus.in_valid = 1'b0;
        check64({name, "_latency"}, {63'h0, bus.out_valid}, 64'h1);
    endtask

    initial begin
        bit acc;
        int accepted;
        int cycles;
        logic [31:0] ra, rb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tc     = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check64("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        check64("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check64("rst_p0", bus.P0, 64'h0);
        check64("rst_p16", bus.P16, 64'h0);
        check64("rst_tag", {60'h0, bus.out_tag}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned small
        direct("u_small", 32'd3, 32'd5, 1'b0, 4'd1);
        check64("u_small_p0", bus.P0, 64'h3);
        check64("u_small_p1", bus.P1, 64'hC);
        check64("u_small_p2", bus.P2, 64'h0);
        check64("u_small_p16", bus.P16, 64'h0);
        check64("u_small_sum", pp_sum(), 64'hF);
        tick(acc);

        // Unsigned max
        direct("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2);
        check64("u_max_p0", bus.P0, 64'hFFFF_FFFF_0000_0001);
        check64("u_max_p1", bus.P1, 64'h0);
        check64("u_max_p8", bus.P8, 64'h0);
        check64("u_max_p15", bus.P15, 64'h0);
        check64("u_max_p16", bus.P16, 64'hFFFF_FFFF_0000_0000);
        check64("u_max_sum", pp_sum(), 64'hFFFF_FFFE_0000_0001);
        tick(acc);

        // Signed -1 * -1
        direct("s_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd3);
        check64("s_m1_p0", bus.P0, 64'h1);
        check64("s_m1_p1", bus.P1, 64'h0);
        check64("s_m1_p16", bus.P16, 64'h0);
        check64("s_m1_sum", pp_sum(), 64'h1);
        tick(acc);

        // Signed most-negative * 2
        direct("s_min", 32'h8000_0000, 32'd2, 1'b1, 4'd4);
        check64("s_min_sum", pp_sum(), 64'hFFFF_FFFF_0000_0000);
        tick(acc);

        // Backpressure: four ops, out_ready low
        bus.out_ready = 1'b0;
        drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'd1);
        tick(acc);
        check64("bp_ready_after1", {63'h0, bus.in_ready}, 64'h1);
        drive(32'hDEAD_BEEF, 32'h0000_0007, 1'b1, 4'd2);
        tick(acc);
        check64("bp_ready_after2", {63'h0, bus.in_ready}, 64'h0);
        drive(32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 4'd3);
        tick(acc);
        check64("bp_blocked", {63'h0, acc}, 64'h0);
        check64("bp_stall_tag", {60'h0, bus.out_tag}, 64'h1);
        tick(acc);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) tick(acc);
        check64("bp_op3_taken", {63'h0, acc}, 64'h1);
        drive(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 4'd4);
        tick(acc);
        check64("bp_op4_taken", {63'h0, acc}, 64'h1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) tick(acc);
        check64("bp_drained", {32'h0, 32'(sb_q.size())}, 64'h0);
        tick(acc);

        // Reset mid-stream with the buffer full
        bus.out_ready = 1'b0;
        drive(32'd11, 32'd13, 1'b0, 4'd5);
        tick(acc);
        drive(32'd17, 32'd19, 1'b0, 4'd6);
        tick(acc);
        bus.in_valid = 1'b0;
        check64("mr_full", {63'h0, bus.in_ready}, 64'h0);
        rst = 1'b1;
        #1;
        check64("mr_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check64("mr_p0", bus.P0, 64'h0);
        check64("mr_p1", bus.P1, 64'h0);
        check64("mr_tag", {60'h0, bus.out_tag}, 64'h0);
        check64("mr_in_ready", {63'h0, bus.in_ready}, 64'h1);
        sb_q.delete();
        stall_prev = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        direct("mr_after", 32'd6, 32'd7, 1'b0, 4'd7);
        check64("mr_after_sum", pp_sum(), 64'd42);
        tick(acc);

        // Random stream
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                ra = $urandom();
                rb = $urandom();
                case ($urandom_range(0, 7))
                    0: ra = 32'hFFFF_FFFF;
                    1: ra = 32'h8000_0000;
                    2: rb = 32'h8000_0000;
                    3: rb = 32'h0;
                    default: ;
                endcase
                drive(ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick(acc);
            cycles++;
            if (acc) begin
                accepted++;
                bus.in_valid = 1'b0;
            end
        end
        check64("rand_accepted", 64'(accepted), 64'd1000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick(acc);
        check64("rand_drained", {32'h0, 32'(sb_q.size())}, 64'h0);
        check64("rand_idle", {63'h0, bus.out_valid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
